// File: rtl/sha256_msg_padder_pkg.sv
// Shared constants and helpers for the SHA-256 message padder: FSM encodings,
// padding constants and the final-word byte merge.
package sha256_msg_padder_pkg;

    localparam logic [2:0] ST_DATA  = 3'd0;
    localparam logic [2:0] ST_PAD   = 3'd1;
    localparam logic [2:0] ST_ZERO  = 3'd2;
    localparam logic [2:0] ST_LENHI = 3'd3;
    localparam logic [2:0] ST_LENLO = 3'd4;

    localparam logic [31:0] SHA_PAD_WORD  = 32'h8000_0000;
    localparam int          SHA_BLK_WORDS = 16;
    localparam int          WIDX_W        = $clog2(SHA_BLK_WORDS);
    localparam logic [WIDX_W-1:0] SHA_LENHI_IDX = 4'd14;
    localparam logic [WIDX_W-1:0] SHA_LENLO_IDX = 4'd15;

    // Keep the nbytes valid leading bytes, put the 0x80 marker right after them.
    function automatic logic [31:0] pad_merge(input logic [31:0] data, input logic [2:0] nbytes);
        case (nbytes)
            3'd0:    pad_merge = SHA_PAD_WORD;
            3'd1:    pad_merge = {data[31:24], 24'h80_0000};
            3'd2:    pad_merge = {data[31:16], 16'h8000};
            3'd3:    pad_merge = {data[31:8], 8'h80};
            default: pad_merge = data;
        endcase
    endfunction

endpackage

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: turns a byte-counted word stream into padded
// 512-bit blocks, one word per cycle through a single output register.
module sha256_msg_padder
    import sha256_msg_padder_pkg::*;
(
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic [2:0]  in_nbytes,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_first,
    output logic        out_blk_last,
    output logic        out_msg_last,
    output logic        busy
);

    // Handshakes: a word moves when valid && ready on a rising edge; the output
    // register refills whenever it is empty or being drained this cycle.
    logic [2:0]        state;
    logic [2:0]        nstate;
    logic [WIDX_W-1:0] widx;
    logic [WIDX_W-1:0] widx_inc;
    logic [63:0]       bitlen;
    logic              emitted;
    logic              ready_en;
    logic              advance;
    logic              accept;
    logic              load;
    logic              msg_last;
    logic [31:0]       word;
    logic [2:0]        after_pad;

    assign advance   = !out_valid || out_ready;
    assign in_ready  = ready_en && (state == ST_DATA) && advance;
    assign accept    = in_valid && in_ready;
    assign widx_inc  = widx + 4'd1;
    // Once the marker is out, zero-fill until the length slot at index 14.
    assign after_pad = (widx_inc == SHA_LENHI_IDX) ? ST_LENHI : ST_ZERO;

    always_comb begin
        load     = 1'b0;
        msg_last = 1'b0;
        word     = 32'h0;
        nstate   = state;
        case (state)
            ST_DATA: begin
                if (accept) begin
                    if (in_last && in_nbytes == 3'd0) begin
                        nstate = ST_PAD;
                    end else if (in_last && in_nbytes != 3'd4) begin
                        load   = 1'b1;
                        word   = pad_merge(in_data, in_nbytes);
                        nstate = after_pad;
                    end else begin
                        load = 1'b1;
                        word = in_data;
                        if (in_last) nstate = ST_PAD;
                    end
                end
            end
            ST_PAD: begin
                load   = 1'b1;
                word   = SHA_PAD_WORD;
                nstate = after_pad;
            end
            ST_ZERO: begin
                load   = 1'b1;
                nstate = after_pad;
            end
            ST_LENHI: begin
                load   = 1'b1;
                word   = bitlen[63:32];
                nstate = ST_LENLO;
            end
            ST_LENLO: begin
                load     = 1'b1;
                word     = bitlen[31:0];
                msg_last = 1'b1;
                nstate   = ST_DATA;
            end
            default: nstate = ST_DATA;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state        <= ST_DATA;
            widx         <= '0;
            bitlen       <= 64'd0;
            emitted      <= 1'b0;
            ready_en     <= 1'b0;
            busy         <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= 32'h0;
            out_first    <= 1'b0;
            out_blk_last <= 1'b0;
            out_msg_last <= 1'b0;
        end else if (clear) begin
            state        <= ST_DATA;
            widx         <= '0;
            bitlen       <= 64'd0;
            emitted      <= 1'b0;
            ready_en     <= 1'b1;
            busy         <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= 32'h0;
            out_first    <= 1'b0;
            out_blk_last <= 1'b0;
            out_msg_last <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (accept) busy <= 1'b1;
            else if (out_valid && out_ready && out_msg_last) busy <= 1'b0;
            if (accept) bitlen <= bitlen + {58'd0, in_nbytes, 3'b000};
            if (advance) begin
                state     <= nstate;
                out_valid <= load;
                if (load) begin
                    out_data     <= word;
                    out_first    <= !emitted;
                    out_blk_last <= (widx == SHA_LENLO_IDX);
                    out_msg_last <= msg_last;
                    if (msg_last) begin
                        widx    <= '0;
                        bitlen  <= 64'd0;
                        emitted <= 1'b0;
                    end else begin
                        widx    <= widx_inc;
                        emitted <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: random messages padded by a byte-level
// reference model, scoreboard compared by an independent output monitor.
module tb_sha256_msg_padder;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'h0;
    logic [2:0]  in_nbytes = 3'd0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_first;
    logic        out_blk_last;
    logic        out_msg_last;
    logic        busy;

    sha256_msg_padder dut (
        .aclk(aclk), .aresetn(aresetn), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_nbytes(in_nbytes), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_first(out_first), .out_blk_last(out_blk_last),
        .out_msg_last(out_msg_last), .busy(busy)
    );

    always #5 aclk = ~aclk;

    int          n_tests = 0;
    int          n_fail = 0;
    int          rdy_mode = 0;   // 0 high, 1 toggle, 2 random, 3 manual
    logic [34:0] exp_q[$];       // {data, first, blk_last, msg_last}
    logic [7:0]  msg[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    always @(posedge aclk) begin
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = ~out_ready;
            2: out_ready = ($urandom_range(0, 3) != 0);
            default: ;
        endcase
    end

    // Output monitor: pops on every handshake, checks holds during stalls.
    logic        prev_stall = 1'b0;
    logic [35:0] prev_out;
    logic [34:0] exp_word;
    always @(negedge aclk) begin
        if (!aresetn || clear) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", {28'd0, out_valid, out_data, out_first, out_blk_last, out_msg_last},
                      {28'd0, prev_out});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %h, expected none", out_data);
                end else begin
                    exp_word = exp_q.pop_front();
                    check("out_word", {29'd0, out_data, out_first, out_blk_last, out_msg_last},
                          {29'd0, exp_word});
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_valid, out_data, out_first, out_blk_last, out_msg_last};
        end
    end

    // Reference: append 0x80, zero-fill to 56 mod 64 bytes, append 64-bit bit length.
    task automatic push_model();
        logic [7:0]  b[$];
        logic [63:0] bits;
        int          nw;
        bits = 64'(msg.size()) * 64'd8;
        b = msg;
        b.push_back(8'h80);
        while (b.size() % 64 != 56) b.push_back(8'h00);
        for (int i = 7; i >= 0; i--) b.push_back(bits[8*i +: 8]);
        nw = b.size() / 4;
        for (int i = 0; i < nw; i++)
            exp_q.push_back({b[4*i], b[4*i+1], b[4*i+2], b[4*i+3],
                             (i == 0), (i % 16 == 15), (i == nw - 1)});
    endtask

    task automatic send_word(input logic [31:0] d, input logic [2:0] nb, input logic last);
        bit acc;
        int cnt;
        acc = 1'b0;
        cnt = 0;
        in_valid  = 1'b1;
        in_data   = d;
        in_nbytes = nb;
        in_last   = last;
        while (!acc) begin
            @(negedge aclk);
            acc = in_ready;
            @(posedge aclk);
            #1;
            cnt++;
            if (!acc && cnt > 1000) begin
                check("in_handshake_timeout", 64'd0, 64'd1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drive_msg(input bit tail_empty);
        int          len;
        int          nb;
        logic [31:0] d;
        len = msg.size();
        if (len == 0) begin
            send_word($urandom, 3'd0, 1'b1);
        end else begin
            for (int i = 0; i < len; i += 4) begin
                nb = (len - i >= 4) ? 4 : len - i;
                d = $urandom;
                for (int k = 0; k < nb; k++) d[31-8*k -: 8] = msg[i+k];
                if (i + 4 >= len && nb == 4 && tail_empty) begin
                    send_word(d, 3'd4, 1'b0);
                    send_word($urandom, 3'd0, 1'b1);
                end else begin
                    send_word(d, 3'(nb), (i + 4 >= len));
                end
            end
        end
    endtask

    task automatic run_random_msg(input int len, input bit tail_empty);
        msg.delete();
        for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
        push_model();
        drive_msg(tail_empty);
    endtask

    task automatic run_abc();
        msg.delete();
        msg.push_back(8'h61);
        msg.push_back(8'h62);
        msg.push_back(8'h63);
        push_model();
        drive_msg(1'b0);
    endtask

    task automatic wait_drain();
        int cnt;
        cnt = 0;
        while ((exp_q.size() != 0 || out_valid) && cnt < 3000) begin
            @(posedge aclk);
            #1;
            cnt++;
        end
        check("drain_remaining", 64'(exp_q.size()), 64'd0);
        repeat (2) @(posedge aclk);
        #1;
    endtask

    task automatic start_partial(input int keep);
        msg.delete();
        for (int i = 0; i < 40; i++) msg.push_back(8'($urandom));
        push_model();
        while (exp_q.size() > keep) void'(exp_q.pop_back());
        for (int i = 0; i < 5; i++) begin
            logic [31:0] d;
            d = {msg[4*i], msg[4*i+1], msg[4*i+2], msg[4*i+3]};
            send_word(d, 3'd4, 1'b0);
        end
    endtask

    initial begin
        repeat (3) @(posedge aclk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_flags", 64'({out_first, out_blk_last, out_msg_last}), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Directed lengths back-to-back with the sink always ready
        rdy_mode = 0;
        run_abc();
        run_random_msg(0, 1'b0);
        run_random_msg(55, 1'b0);
        run_random_msg(56, 1'b0);
        run_random_msg(64, 1'b0);
        wait_drain();
        check("idle_busy", 64'(busy), 64'd0);

        rdy_mode = 1;
        run_random_msg(64, 1'b0);
        run_random_msg(56, 1'b1);
        wait_drain();

        rdy_mode = 2;
        for (int m = 0; m < 20; m++)
            run_random_msg($urandom_range(0, 130), 1'($urandom_range(0, 1)));
        wait_drain();

        // Abort through aresetn while the fifth data word is held in the output
        rdy_mode = 0;
        start_partial(4);
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        check("mid_msg_busy", 64'(busy), 64'd1);
        aresetn = 1'b0;
        #1;
        check("abort_rst_valid", 64'(out_valid), 64'd0);
        check("abort_rst_in_ready", 64'(in_ready), 64'd0);
        check("abort_rst_busy", 64'(busy), 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        check("abort_rst_q_empty", 64'(exp_q.size()), 64'd0);
        run_abc();
        wait_drain();

        // Abort through clear with the word stalled in the output register
        rdy_mode = 3;
        out_ready = 1'b1;
        start_partial(4);
        out_ready = 1'b0;
        clear = 1'b1;
        #1;
        check("pre_clear_valid", 64'(out_valid), 64'd1);
        @(posedge aclk);
        #1;
        clear = 1'b0;
        check("abort_clr_valid", 64'(out_valid), 64'd0);
        check("abort_clr_busy", 64'(busy), 64'd0);
        check("abort_clr_q_empty", 64'(exp_q.size()), 64'd0);
        out_ready = 1'b1;
        rdy_mode = 0;
        run_abc();
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
